// File: rtl/lbp_pkg.sv
// Shared constants and state encoding for the LBP histogram block.
package lbp_pkg;

    localparam int IMG_W    = 128;
    localparam int BINS     = 256;
    localparam int CNT_W    = 14;
    localparam int ADDR_W   = 14;
    localparam int SAMPLE_W = 14;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DUMP  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Border pixels (row/col 0 or IMG_W-1) have no full 3x3 neighbourhood.
    function automatic logic is_interior(input logic [6:0] v);
        return (v != 7'd0) && (v != 7'(IMG_W - 1));
    endfunction

endpackage

// File: rtl/lbp_hist_bank.sv
// Histogram storage: one saturating counter per bin, single increment port,
// combinational read port, synchronous clear.
module lbp_hist_bank #(
    parameter int BINS  = 256,
    parameter int CNT_W = 14,
    parameter int IDX_W = $clog2(BINS)
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc_en,
    input  logic [IDX_W-1:0] i_inc_idx,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [CNT_W-1:0] o_rd_data
);

    logic [CNT_W-1:0] w_bins [BINS];

    // Each bin owns its own register, so back-to-back hits on one bin
    // never lose an update.
    generate
        for (genvar gi = 0; gi < BINS; gi++) begin : gen_bin
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (i_clr) begin
                    r_cnt <= '0;
                end else if (i_inc_en && (i_inc_idx == IDX_W'(gi)) &&
                             (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_bins[gi] = r_cnt;
        end
    endgenerate

    assign o_rd_data = w_bins[i_rd_idx];

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates interior codes, then streams all bins out
// over a valid/ready handshake and parks in DONE until reset.
module lbp_hist #(
    parameter int BINS  = 256,
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic [13:0]      sample_cnt,
    output logic             done
);

    import lbp_pkg::*;

    localparam int IDX_W = $clog2(BINS);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_bin;
    logic [13:0]      r_sample_cnt;

    logic [6:0]       w_row;
    logic [6:0]       w_col;
    logic             w_accept;
    logic             w_xfer;
    logic             w_last;

    assign w_row    = lbp_addr[13:7];
    assign w_col    = lbp_addr[6:0];
    assign w_accept = (r_state == ST_ACCUM) && lbp_valid &&
                      is_interior(w_row) && is_interior(w_col);
    assign w_xfer   = (r_state == ST_DUMP) && hist_ready;
    assign w_last   = (r_bin == IDX_W'(BINS - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (finish)           w_state_next = ST_DUMP;
            ST_DUMP:  if (w_xfer && w_last) w_state_next = ST_DONE;
            ST_DONE:                        w_state_next = ST_DONE;
            default:                        w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_ACCUM;
            r_bin        <= '0;
            r_sample_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_xfer && !w_last) begin
                r_bin <= r_bin + 1'b1;
            end
            if (w_accept && (r_sample_cnt != 14'h3FFF)) begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
        end
    end

    lbp_hist_bank #(
        .BINS  (BINS),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk       (clk),
        .i_clr     (reset),
        .i_inc_en  (w_accept),
        .i_inc_idx (lbp_data[IDX_W-1:0]),
        .i_rd_idx  (r_bin),
        .o_rd_data (hist_count)
    );

    assign hist_valid = (r_state == ST_DUMP);
    assign done       = (r_state == ST_DONE);
    assign hist_bin   = 8'(r_bin);
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_lbp_hist.sv
// Scoreboard bench for lbp_hist: random and directed frames against a
// plain-array histogram model; a monitor checks every dumped bin in order.
module tb_lbp_hist;

    localparam int CNT_MAX = 16383;

    logic        clk = 1'b0;
    logic        reset;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        hist_valid;
    logic        hist_ready;
    logic [7:0]  hist_bin;
    logic [13:0] hist_count;
    logic [13:0] sample_cnt;
    logic        done;

    lbp_hist dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .sample_cnt (sample_cnt),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_hist[256];
    int   m_samples;
    int   ready_mode = 0;
    int   ready_phase = 0;

    function automatic bit interior(input int addr);
        int row, col;
        row = addr / 128;
        col = addr % 128;
        return (row >= 1) && (row <= 126) && (col >= 1) && (col <= 126);
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        hist_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: hist_ready = 1'b1;
                1: begin
                    hist_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
                    ready_phase++;
                end
                default: hist_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops one expected bin per accepted transfer, checks hold on stall.
    initial begin
        bit stall;
        int pb;
        int pc;
        exp_t e;
        stall = 1'b0;
        pb = 0;
        pc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else if (hist_valid) begin
                if (stall) begin
                    n_vec++;
                    if ((int'(hist_bin) != pb) || (int'(hist_count) != pc)) begin
                        n_err++;
                        $display("FAIL hold: bin %0d count %0d, expected bin %0d count %0d",
                                 hist_bin, hist_count, pb, pc);
                    end
                end
                if (hist_ready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_bin: got bin %0d count %0d, expected no transfer",
                                 hist_bin, hist_count);
                    end else begin
                        e = exp_q.pop_front();
                        if ((int'(hist_bin) != e.bin) || (int'(hist_count) != e.cnt)) begin
                            n_err++;
                            $display("FAIL dump_bin: got bin %0d count %0d, expected bin %0d count %0d",
                                     hist_bin, hist_count, e.bin, e.cnt);
                        end else begin
                            $display("bin %0d count %0d ok", hist_bin, hist_count);
                        end
                    end
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    pb = int'(hist_bin);
                    pc = int'(hist_count);
                end
            end else begin
                stall = 1'b0;
            end
        end
    end

    task automatic clear_model();
        for (int b = 0; b < 256; b++) m_hist[b] = 0;
        m_samples = 0;
    endtask

    task automatic model_code(input bit v, input int addr, input int data);
        if (v && interior(addr)) begin
            m_hist[data]++;
            m_samples++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        lbp_valid = 1'b0;
        finish = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        exp_q.delete();
        check("rst_hist_valid", int'(hist_valid), 0);
        check("rst_hist_bin", int'(hist_bin), 0);
        check("rst_hist_count", int'(hist_count), 0);
        check("rst_done", int'(done), 0);
        check("rst_sample_cnt", int'(sample_cnt), 0);
    endtask

    task automatic send(input bit v, input int addr, input int data);
        @(posedge clk);
        #1;
        lbp_valid = v;
        lbp_addr = addr[13:0];
        lbp_data = data[7:0];
        model_code(v, addr, data);
    endtask

    task automatic do_finish(input bit v, input int addr, input int data);
        exp_t e;
        @(posedge clk);
        #1;
        finish = 1'b1;
        lbp_valid = v;
        lbp_addr = addr[13:0];
        lbp_data = data[7:0];
        model_code(v, addr, data);
        for (int b = 0; b < 256; b++) begin
            e.bin = b;
            e.cnt = sat(m_hist[b]);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_dump(input bit abort);
        int cyc;
        bit hit;
        cyc = 0;
        hit = 1'b0;
        while (cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (abort && hist_valid && (hist_bin == 8'd40)) begin
                hit = 1'b1;
                break;
            end
            if (done) break;
            // Codes during DUMP/DONE must be ignored.
            lbp_valid = 1'($urandom_range(0, 1));
            lbp_addr = 14'($urandom);
            lbp_data = 8'($urandom);
        end
        if (abort) begin
            check("abort_reached_bin40", int'(hit), 1);
            reset = 1'b1;
            lbp_valid = 1'b0;
            exp_q.delete();
            @(posedge clk);
            #1;
            check("abort_hist_valid", int'(hist_valid), 0);
            check("abort_done", int'(done), 0);
            check("abort_hist_bin", int'(hist_bin), 0);
            check("abort_hist_count", int'(hist_count), 0);
            check("abort_sample_cnt", int'(sample_cnt), 0);
            reset = 1'b0;
            finish = 1'b0;
            clear_model();
        end else begin
            check("done_asserted", int'(done), 1);
            check("bins_left_undumped", exp_q.size(), 0);
            check("sample_cnt", int'(sample_cnt), sat(m_samples));
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                lbp_valid = 1'b1;
                lbp_addr = 14'd129;
                lbp_data = 8'($urandom);
            end
            lbp_valid = 1'b0;
            check("done_held", int'(done), 1);
            check("sample_cnt_held", int'(sample_cnt), sat(m_samples));
        end
    endtask

    function automatic int rand_interior();
        return (int'($urandom_range(1, 126)) << 7) | int'($urandom_range(1, 126));
    endfunction

    initial begin
        int prev_data;
        int a;
        int d;
        reset = 1'b1;
        lbp_valid = 1'b0;
        lbp_addr = '0;
        lbp_data = '0;
        finish = 1'b0;

        $display("frame 1: ten 0x5A codes, ready pattern 1,0,0,1");
        do_reset();
        ready_mode = 1;
        ready_phase = 0;
        for (int i = 0; i < 10; i++) send(1'b1, rand_interior(), 8'h5A);
        send(1'b0, 0, 0);
        check("f1_sample_cnt", int'(sample_cnt), 10);
        do_finish(1'b0, 0, 0);
        do_dump(1'b0);

        $display("frame 2: border addresses dropped");
        do_reset();
        ready_mode = 0;
        send(1'b1, 0, 1);
        send(1'b1, 127, 1);
        send(1'b1, 16256, 1);
        send(1'b1, 129, 1);
        do_finish(1'b0, 0, 0);
        do_dump(1'b0);

        $display("frame 3: code in the finish cycle");
        do_reset();
        ready_mode = 2;
        for (int i = 0; i < 50; i++) send(1'($urandom_range(0, 1)), rand_interior(), 8'($urandom));
        do_finish(1'b1, 130, 8'hFF);
        do_dump(1'b0);

        $display("frame 4: random stress with same-bin bursts");
        do_reset();
        ready_mode = 2;
        prev_data = 0;
        for (int i = 0; i < 1500; i++) begin
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : rand_interior();
            d = ($urandom_range(0, 1) == 0) ? prev_data : int'($urandom_range(0, 255));
            prev_data = d;
            send(1'($urandom_range(0, 3) != 0), a, d);
        end
        do_finish(1'b0, 0, 0);
        do_dump(1'b0);

        $display("frame 5: full 126x126 frame of code 0x00");
        do_reset();
        ready_mode = 0;
        for (int r = 1; r <= 126; r++)
            for (int c = 1; c <= 126; c++)
                send(1'b1, (r << 7) | c, 0);
        do_finish(1'b0, 0, 0);
        do_dump(1'b0);

        $display("frame 6: bin and sample counter saturation");
        do_reset();
        ready_mode = 1;
        ready_phase = 0;
        for (int i = 0; i < 16400; i++) send(1'b1, 129, 8'h33);
        do_finish(1'b0, 0, 0);
        do_dump(1'b0);

        $display("frame 7: reset at dump bin 40, then empty frame");
        do_reset();
        ready_mode = 2;
        for (int i = 0; i < 30; i++) send(1'b1, rand_interior(), 8'($urandom));
        do_finish(1'b0, 0, 0);
        do_dump(1'b1);
        do_finish(1'b0, 0, 0);
        do_dump(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
